// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the shared register arbiter.
package shared_reg_arbiter_pkg;

  localparam int MAX_REQ   = 32;
  localparam int N_REQ_DEF = 4;
  localparam int OWNER_W   = $clog2(N_REQ_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // One-hot grant at the first set bit of vld[n-1:0], scanning upward from ptr with wrap.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] vld,
                                                 input int ptr,
                                                 input int n);
    logic [MAX_REQ-1:0] gnt;
    int idx;
    gnt = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && gnt == '0 && vld[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             acc_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin
    gnt_o = '0;
    if (en_i) gnt_o = N_REQ'(rr_pick(MAX_REQ'(req_i), int'(ptr_q), N_REQ));
  end

  always_comb begin
    gnt_idx_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_o[k]) gnt_idx_o = IDX_W'(k);
    end
  end

  assign acc_o = |gnt_o;
  assign ptr_d = (gnt_idx_o == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (acc_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shared data register with round-robin write arbitration and a post-write hold window.
//   state | meaning
//   IDLE  | accepts allowed
//   HOLD  | counting down HOLD_CYCLES, all requesters blocked
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int                N_REQ       = 4,
  parameter  int                DATA_W      = 8,
  parameter  logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter  int                HOLD_CYCLES = 0,
  localparam int                IDX_W       = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  input  logic [N_REQ-1:0]        wr_vld,
  output logic [N_REQ-1:0]        wr_rd,
  input  logic                    clr,
  output logic [DATA_W-1:0]       dout,
  output logic                    dout_vld,
  output logic [IDX_W-1:0]        dout_owner,
  output logic                    upd
);

  localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic              vld_q;
  logic [IDX_W-1:0]  owner_q;
  logic              upd_q;

  logic              arb_en;
  logic [IDX_W-1:0]  gnt_idx;
  logic              acc;

  // Reset and clear both suppress the grant, so no accept can coincide with them.
  assign arb_en = (state_q == IDLE) && !clr && !rst;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (wr_vld),
    .en_i      (arb_en),
    .gnt_o     (wr_rd),
    .gnt_idx_o (gnt_idx),
    .acc_o     (acc)
  );

  assign dout_d = wr_data[gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= RESET_VAL;
      vld_q   <= 1'b0;
      owner_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= acc;
      if (clr) begin
        dout_q <= RESET_VAL;
        vld_q  <= 1'b0;
      end else if (acc) begin
        dout_q  <= dout_d;
        vld_q   <= 1'b1;
        owner_q <= gnt_idx;
      end
      // The hold window keeps running through a clear.
      case (state_q)
        IDLE: begin
          if (acc && HOLD_CYCLES > 0) begin
            state_q <= HOLD;
            cnt_q   <= CNT_W'(HOLD_CYCLES);
          end
        end
        HOLD: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = vld_q;
  assign dout_owner = owner_q;
  assign upd        = upd_q;

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin write arbiter and sequencer for one shared data register.
- N_REQ requesters each offer a write over a valid/ready handshake. One winner per accept cycle is written into the register. A programmable hold window then blocks further writes.
- Sits in front of a plain D register stage in the mem example set. It is used where several producers share a single configuration or status register.

Parameters:
- N_REQ, 4, number of requesters; must be ≥2.
- DATA_W, 8, register data width.
- RESET_VAL, 0, register value after reset or clear.
- HOLD_CYCLES, 0, minimum idle cycles after an accepted write before the next accept; 0 allows back-to-back accepts.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_data  in  N_REQ*DATA_W  requester data; slice i = bits [i*DATA_W +: DATA_W]
- wr_vld  in  N_REQ  requester i offers a write
- wr_rd  out  N_REQ  requester i accepted this cycle (one-hot or zero)
- clr  in  1  synchronous clear of register contents
- dout  out  DATA_W  register value
- dout_vld  out  1  register written at least once since reset/clear
- dout_owner  out  clog2(N_REQ)  index of the last writer
- upd  out  1  one-cycle pulse, the cycle after an accept

Behaviour:
- Reset values:
  - dout=RESET_VAL, dout_vld=0, dout_owner=0, upd=0, wr_rd=0.
  - State IDLE, hold counter=0.
  - Round-robin pointer selects index 0 as highest priority.
- States:
  - IDLE: accept allowed.
  - HOLD: counting down HOLD_CYCLES.
- IDLE, any wr_vld set, clr=0:
  - wr_rd is combinationally one-hot at the first set bit, scanning from ptr upward with wrap N_REQ-1→0.
  - wr_rd depends on wr_vld. Requesters must not make wr_vld depend on wr_rd.
- Accept edge (wr_vld[i] & wr_rd[i]):
  - dout<=wr_data slice i; dout_owner<=i; dout_vld<=1; upd<=1 next cycle.
  - ptr<=(i+1) mod N_REQ.
  - If HOLD_CYCLES>0: go to HOLD with counter=HOLD_CYCLES. Otherwise stay in IDLE.
- Latency: dout reflects accepted data exactly 1 cycle after the accept cycle. upd is high in that same cycle.
- HOLD:
  - wr_rd=0.
  - Counter decrements each cycle; when the counter goes 1→0, return to IDLE.
  - Exactly HOLD_CYCLES cycles with wr_rd=0 follow each accept.
- No wr_vld in IDLE: wr_rd=0; ptr, dout and upd are unchanged (upd=0).
- clr=1 (any state):
  - wr_rd=0 that cycle; no accept.
  - Next cycle: dout=RESET_VAL, dout_vld=0, upd=0.
  - dout_owner and ptr are unchanged.
  - State and hold counter are unchanged; HOLD keeps counting.
- rst has priority over clr and over any write; wr_rd=0 while rst=1.
- rst in mid-HOLD: returns to IDLE, ptr=0, the next cycle after rst deasserts may accept.
- A requester holding wr_vld is guaranteed an accept within N_REQ accept opportunities (starvation-free).
- wr_data of non-granted requesters is ignored.

Decomposition:
- Shared package holds:
  - OWNER_W = clog2(N_REQ).
  - State enum {IDLE, HOLD}.
  - A function rr_pick(vld, ptr) that returns a one-hot grant.
- One natural sub-module: rr_arbiter, combinational grant plus registered pointer update on an accept strobe. It is reusable by other shared-resource blocks.
- The data register, dout_vld, owner, upd and the hold counter stay in the top module.

Test Plan:
1. Reset, then wr_vld=0b0101, data0=0x11, data2=0x33, HOLD_CYCLES=0:
   - cycle 0: wr_rd=0b0001
   - cycle 1: dout=0x11, owner=0, upd=1, and wr_rd=0b0100
   - cycle 2: dout=0x33, owner=2
2. All four wr_vld held high for 8 cycles, HOLD_CYCLES=0 → grant sequence 0,1,2,3,0,1,2,3; each requester is accepted exactly twice.
3. HOLD_CYCLES=3, wr_vld[1] held high → accepts on cycles 0, 4, 8; wr_rd=0 on cycles 1-3 and 5-7; upd high on cycles 1, 5, 9.
4. clr asserted in the same cycle as wr_vld[3]=1 with dout=0x5A:
   - wr_rd=0 that cycle.
   - Next cycle: dout=RESET_VAL, dout_vld=0, owner unchanged.
   - The following cycle accepts requester 3.
5. rst pulsed for 1 cycle during HOLD (HOLD_CYCLES=5, counter=3):
   - All outputs return to reset values.
   - With wr_vld=0b1010 the first accept after reset goes to requester 1 (ptr back to 0).
6. wr_vld=0b1000 only, ptr=0 → wrap-around scan grants requester 3; ptr becomes 0; owner=3.
